// File: rtl/sync_fifo_stream_drain_if.sv
// Handshake bundle between the FIFO drain, the FIFO read port and the downstream stream.
// master = drain side, slave = FIFO/stream-consumer side.
interface sync_fifo_stream_drain_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_cs;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_cs, fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_cs, fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/sync_fifo_stream_drain.sv
// Drains a registered-read synchronous FIFO into a valid/ready stream through a 2-entry skid.
// Optional FIFO_DRAIN_STATS_EN adds a saturating transfer counter on port drain_count.
module sync_fifo_stream_drain #(
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  sync_fifo_stream_drain_if.master bus
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [31:0] drain_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                state;
  logic                  rd_en_p0;
  logic [1:0]            occ;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] head_p1;
  logic [DATA_WIDTH-1:0] tail_p1;
  logic                  pop;
  logic                  cap;
  logic                  issue;
  logic [1:0]            occ_nxt;

  assign pop   = vld_p1 && bus.m_ready;
  assign cap   = (state == S_GAP);
  // Only IDLE may issue, so nothing is in flight here and occ alone bounds the skid
  assign issue = (state == S_IDLE) && en && !bus.fifo_empty && (occ < 2'd2);

  always_comb begin
    occ_nxt = occ;
    case ({cap, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // Stage p0: read sequencer, Empty is stale in S_GAP so it is never sampled there
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_en_p0 <= 1'b0;
    end else begin
      rd_en_p0 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            state    <= S_RD;
            rd_en_p0 <= 1'b1;
          end
        end
        S_RD:    state <= S_GAP;
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: skid buffer, head drives the stream, capture lands behind any surviving word
  always_ff @(posedge clk) begin
    if (rst) begin
      occ     <= 2'd0;
      vld_p1  <= 1'b0;
      head_p1 <= '0;
    end else begin
      occ    <= occ_nxt;
      vld_p1 <= (occ_nxt != 2'd0);
      if (pop) begin
        if (occ == 2'd2)
          head_p1 <= tail_p1;
        else if (cap)
          head_p1 <= bus.fifo_data;
      end else if (cap && (occ == 2'd0)) begin
        head_p1 <= bus.fifo_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cap && ((pop && (occ == 2'd2)) || (!pop && (occ == 2'd1))))
      tail_p1 <= bus.fifo_data;
  end

  assign bus.fifo_rd_en = rd_en_p0;
  assign bus.fifo_cs    = rd_en_p0;
  assign bus.m_valid    = vld_p1;
  assign bus.m_data     = head_p1;

`ifdef FIFO_DRAIN_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      drain_count <= 32'd0;
    else if (pop)
      drain_count <= sat_inc(drain_count);
  end
`endif

endmodule

// File: tb/tb_sync_fifo_stream_drain.sv
// Scoreboard bench for sync_fifo_stream_drain against a registered-read, stale-Empty FIFO model.
module tb_sync_fifo_stream_drain;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic fifo_clr;
  always #5 clk = ~clk;

  sync_fifo_stream_drain_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_DRAIN_STATS_EN
  logic [31:0] drain_count;
  sync_fifo_stream_drain #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus), .drain_count(drain_count)
  );
`else
  sync_fifo_stream_drain #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus)
  );
`endif

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int rd_ptr   = 0;
  int rd_count = 0;
  int consec   = 0;
  logic prev_rd = 1'b0;
  int n_pass  = 0;
  int n_total = 0;

  // FIFO model: Empty reflects occupancy before this edge's read; data one cycle after rd_en
  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
      bus.fifo_empty <= 1'b1;
    end else begin
      bus.fifo_empty <= (fq.size() == 0);
      if (bus.fifo_cs && bus.fifo_rd_en && fq.size() > 0) begin
        bus.fifo_data <= fq.pop_front();
        rd_ptr++;
      end
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      if (bus.fifo_rd_en === 1'b1) begin
        rd_count++;
        if (prev_rd) consec++;
      end
      prev_rd = (bus.fifo_rd_en === 1'b1);
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) got_q.push_back(bus.m_data);
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; fifo_clr = 1'b0; bus.m_ready = 1'b1;
    fq.push_back(32'hA5A5_0001);
    exp_q.push_back(32'hA5A5_0001);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_total++;
      if (bus.fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en cyc%0d got %b want 0", c, bus.fifo_rd_en);
      else n_pass++;
      n_total++;
      if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid cyc%0d got %b want 0", c, bus.m_valid);
      else n_pass++;
      n_total++;
      if (bus.m_data !== 32'h0) $display("FAIL reset_m_data cyc%0d got %h want 0", c, bus.m_data);
      else n_pass++;
    end
  endtask

  task automatic test_single_word();
    int rc0;
    logic [DW-1:0] g, e;
    rc0 = rd_count;
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.fifo_rd_en !== 1'b1) $display("FAIL single_rd_en_c1 got %b want 1", bus.fifo_rd_en);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.fifo_rd_en !== 1'b0 || bus.m_valid !== 1'b0)
      $display("FAIL single_c2 got rd_en=%b m_valid=%b want 0/0", bus.fifo_rd_en, bus.m_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.m_valid !== 1'b1) $display("FAIL single_m_valid_c3 got %b want 1", bus.m_valid);
    else n_pass++;
    n_total++;
    if (bus.m_data !== 32'hA5A5_0001) $display("FAIL single_m_data_c3 got %h want a5a50001", bus.m_data);
    else n_pass++;
    repeat (6) @(negedge clk);
    n_total++;
    if (rd_count - rc0 != 1) $display("FAIL single_rd_count got %0d want 1", rd_count - rc0);
    else n_pass++;
    n_total++;
    if (got_q.size() == 0 || exp_q.size() == 0) $display("FAIL single_word got none want a5a50001");
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) $display("FAIL single_word got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_stale_empty();
    int rc0, p0, cs0;
    logic [DW-1:0] g, e;
    rc0 = rd_count; p0 = rd_ptr; cs0 = consec;
    fq.push_back(32'h5A5A_0002);
    exp_q.push_back(32'h5A5A_0002);
    repeat (12) @(negedge clk);
    n_total++;
    if (rd_count - rc0 != 1) $display("FAIL stale_rd_count got %0d want 1", rd_count - rc0);
    else n_pass++;
    n_total++;
    if (rd_ptr - p0 != 1) $display("FAIL stale_rd_ptr got %0d want 1", rd_ptr - p0);
    else n_pass++;
    n_total++;
    if (consec != cs0) $display("FAIL stale_consec got %0d want %0d", consec, cs0);
    else n_pass++;
    n_total++;
    if (got_q.size() == 0 || exp_q.size() == 0) $display("FAIL stale_word got none want 5a5a0002");
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) $display("FAIL stale_word got %h want %h", g, e);
      else n_pass++;
    end
  endtask

  task automatic test_back_pressure();
    int rc0, cs0, cyc;
    logic [DW-1:0] g, e;
    rc0 = rd_count; cs0 = consec;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fq.push_back(DW'(i));
      exp_q.push_back(DW'(i));
    end
    repeat (20) @(negedge clk);
    n_total++;
    if (rd_count - rc0 != 2) $display("FAIL bp_stall_reads got %0d want 2", rd_count - rc0);
    else n_pass++;
    n_total++;
    if (bus.m_valid !== 1'b1) $display("FAIL bp_stall_valid got %b want 1", bus.m_valid);
    else n_pass++;
    n_total++;
    if (bus.m_data !== 32'h0) $display("FAIL bp_stall_data got %h want 0", bus.m_data);
    else n_pass++;
    n_total++;
    if (fq.size() != 6) $display("FAIL bp_fifo_left got %0d want 6", fq.size());
    else n_pass++;
    bus.m_ready = 1'b1;
    cyc = 0;
    while (cyc < 200 && got_q.size() < 8) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (got_q.size() != 8) $display("FAIL bp_drain_count got %0d want 8", got_q.size());
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (got_q.size() == 0 || exp_q.size() == 0) $display("FAIL bp_word%0d got none want %0d", i, i);
      else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) $display("FAIL bp_word%0d got %h want %h", i, g, e);
        else n_pass++;
      end
    end
    n_total++;
    if (consec != cs0) $display("FAIL bp_consecutive_rd_en got %0d want %0d", consec - cs0, 0);
    else n_pass++;
  endtask

  task automatic test_mid_op();
    int rc0, cyc;
    logic [DW-1:0] g, e;
    rc0 = rd_count;
    bus.m_ready = 1'b1; en = 1'b1;
    fq.push_back(32'hC0DE_0001); exp_q.push_back(32'hC0DE_0001);
    fq.push_back(32'hC0DE_0002); exp_q.push_back(32'hC0DE_0002);
    cyc = 0;
    while (cyc < 20 && bus.fifo_rd_en !== 1'b1) begin
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (bus.fifo_rd_en !== 1'b1) $display("FAIL mid_wait_rd_en got %b want 1", bus.fifo_rd_en);
    else n_pass++;
    en = 1'b0;
    repeat (12) @(negedge clk);
    n_total++;
    if (rd_count - rc0 != 1) $display("FAIL mid_en_off_reads got %0d want 1", rd_count - rc0);
    else n_pass++;
    n_total++;
    if (got_q.size() != 1 || exp_q.size() == 0) $display("FAIL mid_inflight got %0d words want 1", got_q.size());
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) $display("FAIL mid_inflight got %h want %h", g, e);
      else n_pass++;
    end
    rc0 = rd_count;
    bus.m_ready = 1'b0;
    fq.push_back(32'hC0DE_0003); exp_q.push_back(32'hC0DE_0003);
    en = 1'b1;
    repeat (16) @(negedge clk);
    n_total++;
    if (rd_count - rc0 != 2) $display("FAIL mid_fill_reads got %0d want 2", rd_count - rc0);
    else n_pass++;
    n_total++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 32'hC0DE_0002)
      $display("FAIL mid_full_head got v=%b d=%h want 1/c0de0002", bus.m_valid, bus.m_data);
    else n_pass++;
    rst = 1'b1; fifo_clr = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.m_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", bus.m_valid);
    else n_pass++;
    exp_q.delete();
    rst = 1'b0; fifo_clr = 1'b0; bus.m_ready = 1'b1;
    repeat (10) @(negedge clk);
    n_total++;
    if (got_q.size() != 0) $display("FAIL mid_rst_dropped got %0d words want 0", got_q.size());
    else n_pass++;
    n_total++;
    if (bus.m_valid !== 1'b0) $display("FAIL mid_rst_idle_valid got %b want 0", bus.m_valid);
    else n_pass++;
    got_q.delete();
  endtask

`ifdef FIFO_DRAIN_STATS_EN
  task automatic test_stats();
    n_total++;
    if (drain_count !== 32'd0) $display("FAIL stats_after_rst got %h want 0", drain_count);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      fq.push_back(32'hBEEF_0000 + DW'(i));
      exp_q.push_back(32'hBEEF_0000 + DW'(i));
    end
    repeat (30) @(negedge clk);
    n_total++;
    if (drain_count !== 32'd5) $display("FAIL stats_five got %0d want 5", drain_count);
    else n_pass++;
    n_total++;
    if (got_q.size() != 5) $display("FAIL stats_words got %0d want 5", got_q.size());
    else n_pass++;
    got_q.delete(); exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_total++;
    if (drain_count !== 32'd0) $display("FAIL stats_rst got %h want 0", drain_count);
    else n_pass++;
    force dut.drain_count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.drain_count;
    for (int i = 0; i < 3; i++) fq.push_back(32'h1234_0000 + DW'(i));
    repeat (20) @(negedge clk);
    n_total++;
    if (drain_count !== 32'hFFFF_FFFF) $display("FAIL stats_saturate got %h want ffffffff", drain_count);
    else n_pass++;
    got_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_stale_empty();
    test_back_pressure();
    test_mid_op();
`ifdef FIFO_DRAIN_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
